// File: rtl/ks_sub_pipe.sv
// Two-stage Kogge-Stone subtractor (A - B - Bin) with valid/ready handshake.
// Define KS_SUB_FLAGS_EN to build the Ovf/Zero flag path; otherwise both tie to 0.
module ks_sub_pipe (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] A,
   input  logic [15:0] B,
   input  logic        Bin,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] Diff,
   output logic        Bout,
   output logic        Ovf,
   output logic        Zero
);

   logic        r_v1;
   logic        r_v2;
   logic [15:0] r_g2;
   logic [15:0] r_p2;
   logic [15:0] r_p0;
   logic        r_cin;
   logic [15:0] r_diff;
   logic        r_bout;

   logic        w_ld1;
   logic        w_ld2;
   logic        w_acc;
   logic [15:0] w_y;
   logic [15:0] w_g0;
   logic [15:0] w_p0;
   logic [15:0] w_g1;
   logic [15:0] w_p1;
   logic [15:0] w_g2;
   logic [15:0] w_p2;
   logic [15:0] w_g4;
   logic [15:0] w_p4;
   logic [15:0] w_g8;
   logic [15:0] w_p8;
   logic [16:0] w_c;
   logic [15:0] w_sum;

   // A stage loads when it is empty or its content leaves in the same cycle.
   assign w_ld2     = ~r_v2 | out_ready;
   assign w_ld1     = ~r_v1 | w_ld2;
   assign in_ready  = ~rst & w_ld1;
   assign w_acc     = in_valid & in_ready;
   assign out_valid = r_v2;

   always_comb begin
      w_y  = ~B;
      w_g0 = A & w_y;
      w_p0 = A ^ w_y;
   end

   always_comb begin
      w_g1 = w_g0;
      w_p1 = w_p0;
      for (int i = 1; i < 16; i++) begin
         w_g1[i] = w_g0[i] | (w_p0[i] & w_g0[i-1]);
         w_p1[i] = w_p0[i] & w_p0[i-1];
      end
   end

   always_comb begin
      w_g2 = w_g1;
      w_p2 = w_p1;
      for (int i = 2; i < 16; i++) begin
         w_g2[i] = w_g1[i] | (w_p1[i] & w_g1[i-2]);
         w_p2[i] = w_p1[i] & w_p1[i-2];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_v1  <= 1'b0;
         r_g2  <= '0;
         r_p2  <= '0;
         r_p0  <= '0;
         r_cin <= 1'b0;
      end else begin
         if (w_ld1) r_v1 <= in_valid;
         if (w_acc) begin
            r_g2  <= w_g2;
            r_p2  <= w_p2;
            r_p0  <= w_p0;
            r_cin <= ~Bin;
         end
      end
   end

   always_comb begin
      w_g4 = r_g2;
      w_p4 = r_p2;
      for (int i = 4; i < 16; i++) begin
         w_g4[i] = r_g2[i] | (r_p2[i] & r_g2[i-4]);
         w_p4[i] = r_p2[i] & r_p2[i-4];
      end
   end

   always_comb begin
      w_g8 = w_g4;
      w_p8 = w_p4;
      for (int i = 8; i < 16; i++) begin
         w_g8[i] = w_g4[i] | (w_p4[i] & w_g4[i-8]);
         w_p8[i] = w_p4[i] & w_p4[i-8];
      end
   end

   // Group terms now span [i:0]; fold in the carry-in as a final generate.
   always_comb begin
      w_c[0] = r_cin;
      for (int i = 0; i < 16; i++) begin
         w_c[i+1] = w_g8[i] | (w_p8[i] & r_cin);
      end
      w_sum = r_p0 ^ w_c[15:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_v2   <= 1'b0;
         r_diff <= '0;
         r_bout <= 1'b0;
      end else if (w_ld2) begin
         r_v2 <= r_v1;
         if (r_v1) begin
            r_diff <= w_sum;
            r_bout <= ~w_c[16];
         end
      end
   end

   assign Diff = r_diff;
   assign Bout = r_bout;

`ifdef KS_SUB_FLAGS_EN
   logic r_ovf;
   logic r_zero;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ovf  <= 1'b0;
         r_zero <= 1'b0;
      end else if (w_ld2 && r_v1) begin
         r_ovf  <= w_c[15] ^ w_c[16];
         r_zero <= ~|w_sum;
      end
   end

   assign Ovf  = r_ovf;
   assign Zero = r_zero;
`else
   assign Ovf  = 1'b0;
   assign Zero = 1'b0;
`endif

endmodule

// File: tb/tb_ks_sub_pipe.sv
// Scoreboard bench for ks_sub_pipe: reference results queued at acceptance,
// compared in order when the DUT hands a result over.
module tb_ks_sub_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] A;
   logic [15:0] B;
   logic        Bin;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] Diff;
   logic        Bout;
   logic        Ovf;
   logic        Zero;

`ifdef KS_SUB_FLAGS_EN
   localparam bit FLAGS = 1'b1;
`else
   localparam bit FLAGS = 1'b0;
`endif

   int          n_checks = 0;
   int          n_errors = 0;
   int          n_acc    = 0;
   logic [18:0] q[$];
   logic [18:0] e;

   always #5 clk = ~clk;

   ks_sub_pipe dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .Bin       (Bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Diff      (Diff),
      .Bout      (Bout),
      .Ovf       (Ovf),
      .Zero      (Zero)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: {diff, borrow, ovf, zero} from plain integer arithmetic.
   function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b, input logic bin);
      logic [15:0] d;
      logic        bo;
      logic        ov;
      logic        z;
      int          sd;
      d  = a - b - {15'b0, bin};
      bo = ({1'b0, a} < ({1'b0, b} + {16'b0, bin}));
      sd = int'($signed(a)) - int'($signed(b)) - int'(bin);
      ov = (sd > 32767) || (sd < -32768);
      z  = (d == 16'h0000);
      return {d, bo, ov & FLAGS, z & FLAGS};
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         q.delete();
      end else begin
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk("unexpected_out", 32'(Diff), 32'hdead);
            end else begin
               e = q.pop_front();
               chk("sb_diff", 32'(Diff), 32'(e[18:3]));
               chk("sb_bout", 32'(Bout), 32'(e[2]));
               chk("sb_ovf",  32'(Ovf),  32'(e[1]));
               chk("sb_zero", 32'(Zero), 32'(e[0]));
            end
         end
         if (in_valid && in_ready) begin
            q.push_back(model(A, B, Bin));
            n_acc++;
         end
      end
   end

   task automatic send(input logic [15:0] a, input logic [15:0] b, input logic bin);
      logic acc;
      acc      = 1'b0;
      A        = a;
      B        = b;
      Bin      = bin;
      in_valid = 1'b1;
      for (int t = 0; t < 100; t++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         if (acc) break;
      end
      if (!acc) chk("send_timeout", 32'(acc), 32'd1);
      in_valid = 1'b0;
   endtask

   // Single transfer into an empty pipe with out_ready=1, checked at fixed latency.
   task automatic one(input logic [15:0] a, input logic [15:0] b, input logic bin,
                      input logic [15:0] ed, input logic eb, input logic eo, input logic ez);
      send(a, b, bin);
      @(negedge clk);
      chk("lat_stage1", 32'(out_valid), 32'd0);
      @(negedge clk);
      chk("lat_valid", 32'(out_valid), 32'd1);
      chk("dir_diff", 32'(Diff), 32'(ed));
      chk("dir_bout", 32'(Bout), 32'(eb));
      chk("dir_ovf",  32'(Ovf),  32'(eo & FLAGS));
      chk("dir_zero", 32'(Zero), 32'(ez & FLAGS));
      @(posedge clk);
      #1;
   endtask

   logic [15:0] ta   [4] = '{16'h1111, 16'h0000, 16'h8000, 16'hABCD};
   logic [15:0] tb_v [4] = '{16'h0101, 16'h0001, 16'h0001, 16'h1234};
   logic        tbin [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
   logic [18:0] first;
   int          idx;
   int          start;

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      A         = '0;
      B         = '0;
      Bin       = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd0);
      chk("rst_diff",      32'(Diff),      32'd0);
      chk("rst_bout",      32'(Bout),      32'd0);
      chk("rst_ovf",       32'(Ovf),       32'd0);
      chk("rst_zero",      32'(Zero),      32'd0);
      @(posedge clk);
      #1;
      rst       = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;

      one(16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
      one(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
      one(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
      one(16'h1234, 16'h1233, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
      one(16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);

      // Stall with out_ready low: only two entries fit, output frozen on the first.
      out_ready = 1'b0;
      idx       = 0;
      first     = model(ta[0], tb_v[0], tbin[0]);
      for (int c = 1; c <= 5; c++) begin
         A        = ta[idx];
         B        = tb_v[idx];
         Bin      = tbin[idx];
         in_valid = 1'b1;
         @(negedge clk);
         if (c >= 3) begin
            chk("full_in_ready", 32'(in_ready),  32'd0);
            chk("stall_valid",   32'(out_valid), 32'd1);
            chk("stall_diff",    32'(Diff),      32'(first[18:3]));
            chk("stall_bout",    32'(Bout),      32'(first[2]));
         end
         if (in_ready) idx++;
         @(posedge clk);
         #1;
      end
      chk("stall_accepted", 32'(idx), 32'd2);
      out_ready = 1'b1;
      for (int t = 0; t < 50 && idx < 4; t++) begin
         A        = ta[idx];
         B        = tb_v[idx];
         Bin      = tbin[idx];
         in_valid = 1'b1;
         @(negedge clk);
         if (in_ready) idx++;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      chk("stall_all_in", 32'(idx), 32'd4);
      repeat (4) @(posedge clk);
      #1;
      chk("stall_drained", 32'(q.size()), 32'd0);

      // Reset with two results in flight: none of them may surface afterwards.
      out_ready = 1'b0;
      send(16'h4444, 16'h1111, 1'b0);
      send(16'h9999, 16'h0009, 1'b1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("flush_valid", 32'(out_valid), 32'd0);
      chk("flush_diff",  32'(Diff),      32'd0);
      chk("flush_bout",  32'(Bout),      32'd0);
      chk("flush_ovf",   32'(Ovf),       32'd0);
      chk("flush_zero",  32'(Zero),      32'd0);
      chk("flush_ready", 32'(in_ready),  32'd1);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      one(16'h0100, 16'h0001, 1'b1, 16'h00FE, 1'b0, 1'b0, 1'b0);
      repeat (5) @(posedge clk);
      #1;

      // Random regression with random handshake pressure on both sides.
      start = n_acc;
      for (int t = 0; t < 60000 && (n_acc - start) < 10000; t++) begin
         case ($urandom_range(0, 7))
            0:       A = 16'h8000;
            1:       A = 16'h0000;
            2:       A = 16'hFFFF;
            default: A = 16'($urandom);
         endcase
         B         = ($urandom_range(0, 7) == 0) ? A : 16'($urandom);
         Bin       = 1'($urandom_range(0, 1));
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 7);
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("rand_count", 32'(((n_acc - start) >= 10000) ? 1 : 0), 32'd1);
      for (int t = 0; t < 100 && q.size() != 0; t++) begin
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      chk("final_empty", 32'(q.size()), 32'd0);
      chk("final_valid", 32'(out_valid), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ks_sub_pipe.md
KS_SUB_PIPE -- requirements
Module: ks_sub_pipe

Interface
REQ-001 The block SHALL have no parameters; the operand width SHALL be fixed at 16 bits.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 in_valid  input  1  the operand set on A/B/Bin is valid.
REQ-005 in_ready  output  1  the block accepts the operand set this cycle.
REQ-006 A  input  16  minuend, unsigned or two's complement.
REQ-007 B  input  16  subtrahend.
REQ-008 Bin  input  1  borrow-in.
REQ-009 out_valid  output  1  Diff/Bout/Ovf/Zero are valid.
REQ-010 out_ready  input  1  the consumer takes the result this cycle.
REQ-011 Diff  output  16  (A - B - Bin) mod 2^16.
REQ-012 Bout  output  1  borrow-out: 1 when unsigned A < B + Bin.
REQ-013 Ovf  output  1  signed overflow of the subtraction.
REQ-014 Zero  output  1  Diff == 16'h0000.

Function
REQ-015 Subtraction SHALL be computed as A + ~B + ~Bin using a Kogge-Stone prefix tree (radix-2, distances 1/2/4/8); Bout SHALL equal the inverted carry out of bit 15.
REQ-016 Stage 1 SHALL register G/P after prefix distances 1 and 2, together with P0 and the carry-in; stage 2 SHALL register Diff/Bout/Ovf/Zero after distances 4 and 8 and the sum XOR.
REQ-017 Latency SHALL be exactly 2 cycles from an accepted transfer (in_valid & in_ready) to out_valid, with no stalls; throughput SHALL be 1 result per cycle.
REQ-018 Each stage SHALL hold a valid bit; a stage SHALL load when it is empty or its content moves downstream in the same cycle.
REQ-019 in_ready SHALL be 1 when stage 1 is empty or stage 1 advances this cycle; it SHALL NOT depend combinationally on in_valid.
REQ-020 While out_valid=1 and out_ready=0, Diff/Bout/Ovf/Zero SHALL hold stable; a full pipeline SHALL hold exactly 2 entries, and in_ready SHALL then be 0.
REQ-021 A simultaneous output handshake and input acceptance on a full pipeline SHALL shift the pipeline with no loss or duplication; results SHALL leave in acceptance order.
REQ-022 Ovf SHALL equal the carry into bit 15 XOR the carry out of bit 15 of A + ~B + ~Bin.
REQ-023 Wrap-around SHALL be modular: 16'h0000 - 16'h0001 gives Diff=16'hFFFF, Bout=1.

Reset
REQ-024 When rst=1 at a rising edge, both valid bits SHALL clear, and Diff, Bout, Ovf and Zero SHALL be driven to 0.
REQ-025 During reset, out_valid=0 and in_ready=0; in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-026 A reset during operation SHALL discard all in-flight results; no stale result SHALL appear after reset.

Configuration
REQ-027 Macro KS_SUB_FLAGS_EN: when defined, Ovf and Zero SHALL be computed and pipelined as specified in REQ-013, REQ-014 and REQ-022.
REQ-028 When KS_SUB_FLAGS_EN is not defined, Ovf and Zero SHALL be constant 0, no flag logic or flag registers SHALL exist, and Diff/Bout/timing SHALL be unchanged.

Verification
REQ-029 A=16'h0005, B=16'h0003, Bin=0, out_ready=1 -> 2 cycles later: out_valid=1, Diff=16'h0002, Bout=0, Ovf=0, Zero=0.
REQ-030 A=16'h0000, B=16'h0001, Bin=0 -> Diff=16'hFFFF, Bout=1, Ovf=0; A=16'h8000, B=16'h0001 -> Diff=16'h7FFF, Bout=0, Ovf=1 (Ovf=0 without KS_SUB_FLAGS_EN).
REQ-031 A=16'h1234, B=16'h1233, Bin=1 -> Diff=16'h0000, Bout=0, Zero=1.
REQ-032 Back-to-back 4 transfers with out_ready=0 for cycles 1-5 -> exactly 2 transfers accepted, in_ready=0 from cycle 3, outputs stable; after out_ready=1, all 4 results emerge in order with no loss.
REQ-033 rst asserted for one cycle while 2 results are in flight -> out_valid=0 next cycle, all outputs 0, and the next result corresponds only to the first post-reset transfer.
REQ-034 Random regression of 10000 transfers with random in_valid/out_ready -> every result matches (A - B - Bin) mod 2^16 and its borrow/flags in order.
